// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: shared definitions for the chunked sequential adder.
//   - State encoding constants and the FSM state enum.
//   - clog2 helper used to size the chunk index register.
package adder_seq_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } state_t;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_seq_chunk.sv
// adder_seq_chunk: combinational N-bit adder slice with carry in/out.
// Ports:
//   x, y  : N-bit addends
//   ci    : carry in
//   s     : N-bit sum
//   co    : carry out of bit N-1
module adder_seq_chunk #(
    parameter int N = 16
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    // N+1 bit sum; the top bit is the chunk carry.
    assign {co, s} = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};

endmodule

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: W-bit adder built by reusing one N-bit chunk adder over
// K = W/N cycles, low chunk first, with the carry held in a register.
//
// Optional feature macro: ADDER_SEQ_SUB_EN adds a `sub` input; when set at
// acceptance the result is a - b mod 2^W and cout = 1 means no borrow.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. start_ready is high only in IDLE; res_valid is high only in
// DONE and sum/cout stay stable until the result transfer. Operand and
// result transfers never happen on the same edge.
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   start_valid/ready     : operand handshake (a, b, cin[, sub])
//   res_valid/res_ready   : result handshake (sum, cout)
//   busy                  : state != IDLE
//   dbg_state             : current FSM state encoding (IDLE/RUN/DONE)
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int W = 64,
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef ADDER_SEQ_SUB_EN
    input  logic         sub,
`endif
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    localparam int K     = W / N;
    localparam int IDX_W = (clog2(K) < 1) ? 1 : clog2(K);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;

    logic [N-1:0]     chunk_s;
    logic             chunk_co;

    adder_seq_chunk #(.N(N)) u_chunk (
        .x  (a_q[idx*N +: N]),
        .y  (b_q[idx*N +: N]),
        .ci (carry),
        .s  (chunk_s),
        .co (chunk_co)
    );

    assign start_ready = (state == ST_IDLE);
    assign res_valid   = (state == ST_DONE);
    assign busy        = (state != ST_IDLE);
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        a_q <= a;
`ifdef ADDER_SEQ_SUB_EN
                        // Subtraction as a + ~b + 1: invert b once at capture.
                        b_q   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
`else
                        b_q   <= b;
                        carry <= cin;
`endif
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum[idx*N +: N] <= chunk_s;
                    carry           <= chunk_co;
                    if (idx == IDX_LAST) begin
                        cout  <= chunk_co;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed bench for adder_seq_ctrl (W=64/N=16 and the
// single-chunk W=N=16 case). Build with ADDER_SEQ_SUB_EN to cover subtraction.
module tb_adder_seq_ctrl;

    logic        clk;
    logic        rst_n;

    // W=64, N=16 instance
    logic        start_valid, start_ready, cin, res_valid, res_ready, cout, busy;
    logic [63:0] a, b, sum;
    logic [1:0]  dbg_state;
    logic        sub_i;

    // W=N=16 instance
    logic        sv_s, sr_s, cin_s, rv_s, rr_s, cout_s, busy_s;
    logic [15:0] a_s, b_s, sum_s;
    logic [1:0]  dbg_s;

    int tests;
    int fails;

    adder_seq_ctrl #(.W(64), .N(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .cin(cin),
`ifdef ADDER_SEQ_SUB_EN
        .sub(sub_i),
`endif
        .res_valid(res_valid), .res_ready(res_ready),
        .sum(sum), .cout(cout), .busy(busy), .dbg_state(dbg_state)
    );

    adder_seq_ctrl #(.W(16), .N(16)) dut_k1 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv_s), .start_ready(sr_s),
        .a(a_s), .b(b_s), .cin(cin_s),
`ifdef ADDER_SEQ_SUB_EN
        .sub(1'b0),
`endif
        .res_valid(rv_s), .res_ready(rr_s),
        .sum(sum_s), .cout(cout_s), .busy(busy_s), .dbg_state(dbg_s)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One operation on the 64-bit instance. bp = cycles of result backpressure.
    task automatic do_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                         input logic ci, input logic sb, input int bp,
                         input logic [63:0] exp_sum, input logic exp_cout);
        int cnt;
        res_ready   = (bp == 0);
        a           = av;
        b           = bv;
        cin         = ci;
        sub_i       = sb;
        start_valid = 1'b1;
        tick();                                   // accepting edge
        start_valid = 1'b0;
        a           = $urandom();                 // late operand changes must not matter
        b           = {$urandom(), $urandom()};
        cin         = ~ci;
        sub_i       = ~sb;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_sr_run"}, 64'(start_ready), 64'd0);
        check({tag, "_state_run"}, 64'(dbg_state), 64'd1);
        start_valid = 1'b1;                       // ignored while running
        cnt = 0;
        while (!res_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        start_valid = 1'b0;
        check({tag, "_latency"}, 64'(cnt), 64'd4);
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
        for (int i = 0; i < bp; i++) begin
            start_valid = 1'b1;
            tick();
            check({tag, "_bp_valid"}, 64'(res_valid), 64'd1);
            check({tag, "_bp_sum"}, sum, exp_sum);
            check({tag, "_bp_cout"}, 64'(cout), 64'(exp_cout));
            check({tag, "_bp_sr"}, 64'(start_ready), 64'd0);
        end
        start_valid = 1'b0;
        res_ready   = 1'b1;
        tick();                                   // result accepted
        check({tag, "_rv_low"}, 64'(res_valid), 64'd0);
        check({tag, "_sr_idle"}, 64'(start_ready), 64'd1);
    endtask

    initial begin
        int cnt;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub_i = 1'b0;
        sv_s = 1'b0; rr_s = 1'b0; a_s = '0; b_s = '0; cin_s = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_sr", 64'(start_ready), 64'd1);
        check("rst_rv", 64'(res_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sum", sum, 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_k1_sr", 64'(sr_s), 64'd1);
        rst_n = 1'b1;
        tick();

        // Basic adds and carry propagation
        do_op("basic", 64'd100000000, 64'd50000000, 1'b1, 1'b0, 0, 64'd150000001, 1'b0);
        tick();
        check("idle_hold_sum", sum, 64'd150000001);
        check("idle_busy", 64'(busy), 64'd0);
        do_op("chunk_carry", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 0,
              64'h0000_0000_0001_0000, 1'b0);
        do_op("all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 0, 64'd0, 1'b1);
        do_op("multi_chunk", 64'h0000_FFFF_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 0,
              64'h0001_0000_0000_0000, 1'b0);
        do_op("pattern", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 0,
              64'h1234_5678_9ABC_DF00, 1'b0);

        // Backpressure with ignored start pulses
        do_op("bp", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0, 1'b0, 5,
              64'd1, 1'b1);
        tick();
        check("bp_no_requeue", 64'(busy), 64'd0);

        // Reset in the middle of RUN (idx = 2)
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; cin = 1'b1;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrun_state", 64'(dbg_state), 64'd0);
        check("midrun_sum", sum, 64'd0);
        check("midrun_cout", 64'(cout), 64'd0);
        check("midrun_rv", 64'(res_valid), 64'd0);
        check("midrun_busy", 64'(busy), 64'd0);
        do_op("after_rst", 64'd1000, 64'd2000, 1'b0, 1'b0, 0, 64'd3000, 1'b0);

        // Single-chunk instance (K = 1)
        rr_s = 1'b0;
        a_s = 16'hFFFF; b_s = 16'd1; cin_s = 1'b0; sv_s = 1'b1;
        tick();
        sv_s = 1'b0;
        a_s = 16'h1234;
        cnt = 0;
        while (!rv_s && cnt < 20) begin
            tick();
            cnt++;
        end
        check("k1_latency", 64'(cnt), 64'd1);
        check("k1_sum", 64'(sum_s), 64'd0);
        check("k1_cout", 64'(cout_s), 64'd1);
        tick();
        check("k1_hold", 64'(rv_s), 64'd1);
        rr_s = 1'b1;
        tick();
        check("k1_sr_idle", 64'(sr_s), 64'd1);
        check("k1_busy", 64'(busy_s), 64'd0);

`ifdef ADDER_SEQ_SUB_EN
        do_op("sub_neg", 64'd5, 64'd10, 1'b0, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
        do_op("sub_pos", 64'd10, 64'd5, 1'b0, 1'b1, 0, 64'd5, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
